ov_sccb_cfg: RTL
================

Name: ov_sccb_cfg

Overview:
Power-up configuration sequencer for the OV2640 camera. It walks an external register table and issues one SCCB 3-phase write (device ID, register address, data) per entry over SIOC/SIOD. It runs before the pixel capture path and asserts cfg_done once the sensor is configured. The table lives outside the block (ROM/LUT), so sensor settings change without touching this RTL.

Parameters:
SCL_DIV, 250, clk cycles per SIOC quarter-period (100 MHz -> 100 kHz SIOC); minimum 2
INIT_DELAY, 1000000, clk cycles of power-up wait, and the length of a table delay sentinel
REG_NUM, 200, number of table entries, 1..256
DEV_ADDR, 8'h60, SCCB write ID byte

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous and active-low
start  in  1  single-cycle pulse; re-runs the whole sequence when in DONE
tbl_idx  out  8  table entry index
tbl_data  in  16  {reg_addr[15:8], reg_data[7:0]}; valid 1 clk after tbl_idx changes
sioc  out  1  SCCB clock
siod_o  out  1  SIOD drive value (always 0 when driven)
siod_oe  out  1  1 = pull SIOD low, 0 = release (pull-up gives high)
siod_i  in  1  SIOD pin readback
busy  out  1  sequence in progress
cfg_done  out  1  all entries written; held until start or reset
nack_cnt  out  8  count of ack slots read high; saturates at 255

Behaviour:
- Reset (rst=0, async): sioc=1, siod_oe=0, siod_o=0, tbl_idx=0, busy=0, cfg_done=0, nack_cnt=0, state=IDLE, all counters cleared. Reset mid-transfer releases the bus the same instant.
- Quarter tick: a prescaler produces a 1-clk tick every SCL_DIV clks. All bus activity advances on ticks only.
- States:
  - IDLE: entered on reset. On the first clk after release, go to PWRUP (busy=1).
  - PWRUP: count INIT_DELAY clks, then go to FETCH.
  - FETCH: set tbl_idx and wait 2 clks, then latch tbl_data.
    - If tbl_data = 16'hFFF0 (delay sentinel), go to DELAY.
    - Otherwise load the shift frame {DEV_ADDR, reg_addr, reg_data} and go to START.
  - START: 4 ticks.
    - q0: sioc=1, SIOD released.
    - q1: SIOD low.
    - q2: still low.
    - q3: sioc=0.
  - BITS: 27 bit slots (3 bytes x 9 bits), MSB first, 4 ticks per slot.
    - q0: sioc=0, set SIOD.
    - q1: hold.
    - q2: sioc=1.
    - q3: sioc=1.
    - The 9th slot of each byte releases SIOD (don't-care/ack). siod_i is sampled at the q2 tick; if it reads 1, nack_cnt increments. The write continues regardless.
  - STOP: 4 ticks.
    - q0: sioc=0, SIOD low.
    - q1: sioc=1.
    - q2: SIOD released.
    - q3: idle.
  - GAP: 4 ticks with the bus idle (sioc=1, SIOD released).
    - If tbl_idx = REG_NUM-1, go to DONE.
    - Otherwise tbl_idx+1, then FETCH.
  - DELAY: INIT_DELAY clks with the bus idle, then advance the index exactly as GAP does. No bus activity.
  - DONE: busy=0, cfg_done=1, tbl_idx holds its last value. A start pulse clears cfg_done, sets tbl_idx=0 and nack_cnt=0, and goes to PWRUP.
- Timing: one register write is 120 ticks (4 + 108 + 4 + 4) plus the fetch clks.
- start is ignored unless the state is DONE.
- siod_o is tied to 0. SIOD is only ever pulled low or released, never driven high.
- The 8-bit tbl_idx increment never wraps, because REG_NUM is at most 256.

Test Plan (SCL_DIV=2, INIT_DELAY=16, REG_NUM=3, bench open-drain SIOD model with pull-up, SCCB monitor):
1. Release rst: busy rises after 1 clk; sioc=1 and SIOD high until the first START; the SIOD fall occurs at least 16 clks after release.
2. Table {FF01, 1280, 1101}, slave acks low: monitor decodes 60/FF/01, 60/12/80, 60/11/01 in order; tbl_idx goes 0,1,2; cfg_done=1, busy=0, nack_cnt=0.
3. Table {FF01, FFF0, 1101}: exactly two bus transactions, separated by at least 16 idle clks with sioc=1 and SIOD high.
4. No slave (siod_i stays high): all 3 writes still complete; nack_cnt=9; cfg_done=1.
5. Assert rst during the 2nd byte of write 1: sioc=1, siod_oe=0 and busy=0 immediately. After release the sequence restarts at tbl_idx=0 and the monitor sees complete writes only.
6. start pulse while busy: no effect. start pulse in DONE: cfg_done drops next clk and all 3 writes repeat identically.

Source files
------------

// File: rtl/ov_sccb_cfg.sv
// Power-up SCCB configuration sequencer for the OV2640. Walks an external
// register table and issues one 3-phase SCCB write (ID, reg, data) per entry.
module ov_sccb_cfg #(
  parameter int          SCL_DIV    = 250,
  parameter int          INIT_DELAY = 1000000,
  parameter int          REG_NUM    = 200,
  parameter logic [7:0]  DEV_ADDR   = 8'h60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  tbl_idx,
  input  logic [15:0] tbl_data,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe,
  input  logic        siod_i,
  output logic        busy,
  output logic        cfg_done,
  output logic [7:0]  nack_cnt
);
  localparam int          PW         = $clog2(SCL_DIV);
  localparam int          DW         = $clog2(INIT_DELAY + 1);
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;
  localparam logic [26:0] ACK_SLOTS  = 27'h0040201;
  localparam logic [7:0]  LAST_IDX   = 8'(REG_NUM - 1);

  // state   | meaning
  // IDLE    | just out of reset
  // PWRUP   | sensor power-up wait
  // FETCH   | present tbl_idx, latch tbl_data
  // START   | SCCB start condition
  // BITS    | 27 bit slots (3 bytes + don't-care bits)
  // STOP    | SCCB stop condition
  // GAP     | idle bus between writes
  // DELAY   | table-requested wait, bus idle
  // DONE    | table complete
  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre_cnt;
  logic [DW-1:0] dly_cnt;
  logic [1:0]    fetch_cnt;
  logic [1:0]    q;
  logic [4:0]    bit_cnt;
  logic [26:0]   shreg;
  logic [26:0]   ack_mask;
  logic          tick, q_end, last, dly_done, restart;

  assign tick     = (pre_cnt == '0);
  assign q_end    = tick && (q == 2'd3);
  assign last     = (tbl_idx == LAST_IDX);
  assign dly_done = (dly_cnt == '0);
  assign restart  = (state == S_DONE) && start;
  assign siod_o   = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_PWRUP;
      S_PWRUP: if (dly_done) state_nxt = S_FETCH;
      S_FETCH: if (fetch_cnt == 2'd2)
                 state_nxt = (tbl_data == DELAY_MARK) ? S_DELAY : S_START;
      S_START: if (q_end) state_nxt = S_BITS;
      S_BITS:  if (q_end && bit_cnt == 5'd26) state_nxt = S_STOP;
      S_STOP:  if (q_end) state_nxt = S_GAP;
      S_GAP:   if (q_end) state_nxt = last ? S_DONE : S_FETCH;
      S_DELAY: if (dly_done) state_nxt = last ? S_DONE : S_FETCH;
      S_DONE:  if (start) state_nxt = S_PWRUP;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sioc     = 1'b1;
    siod_oe  = 1'b0;
    busy     = (state != S_IDLE) && (state != S_DONE);
    cfg_done = (state == S_DONE);
    case (state)
      S_START: begin
        sioc    = (q != 2'd3);
        siod_oe = (q != 2'd0);
      end
      S_BITS: begin
        sioc    = q[1];
        siod_oe = ~shreg[26];
      end
      S_STOP: begin
        sioc    = (q != 2'd0);
        siod_oe = ~q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt   <= '0;
      dly_cnt   <= '0;
      fetch_cnt <= 2'd0;
      q         <= 2'd0;
      bit_cnt   <= 5'd0;
      shreg     <= '1;
      ack_mask  <= '0;
      tbl_idx   <= 8'd0;
      nack_cnt  <= 8'd0;
    end else begin
      pre_cnt <= tick ? PW'(SCL_DIV - 1) : pre_cnt - 1'b1;

      if ((state_nxt == S_PWRUP || state_nxt == S_DELAY) && state_nxt != state)
        dly_cnt <= DW'(INIT_DELAY - 1);
      else if (!dly_done)
        dly_cnt <= dly_cnt - 1'b1;

      fetch_cnt <= (state == S_FETCH) ? fetch_cnt + 2'd1 : 2'd0;

      if (state == S_FETCH)
        q <= 2'd0;
      else if (tick && (state inside {S_START, S_BITS, S_STOP, S_GAP}))
        q <= q + 2'd1;

      // ack slots carry a 1 so the shifter releases SIOD there
      if (state == S_FETCH && fetch_cnt == 2'd2) begin
        shreg    <= {DEV_ADDR, 1'b1, tbl_data[15:8], 1'b1, tbl_data[7:0], 1'b1};
        ack_mask <= ACK_SLOTS;
        bit_cnt  <= 5'd0;
      end else if (state == S_BITS && q_end) begin
        shreg    <= {shreg[25:0], 1'b1};
        ack_mask <= {ack_mask[25:0], 1'b0};
        bit_cnt  <= bit_cnt + 5'd1;
      end

      if (restart)
        nack_cnt <= 8'd0;
      else if (state == S_BITS && tick && q == 2'd2 && ack_mask[26] && siod_i
               && nack_cnt != 8'hFF)
        nack_cnt <= nack_cnt + 8'd1;

      if (restart)
        tbl_idx <= 8'd0;
      else if (((state == S_GAP && q_end) || (state == S_DELAY && dly_done)) && !last)
        tbl_idx <= tbl_idx + 8'd1;
    end
  end
endmodule
